// File: rtl/mem_wb_stage_pkg.sv
// ============================================================================
// Module : mem_wb_stage_pkg
// Brief  : Shared field indices and widths for the MEM/WB stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_wb_stage_pkg;

    localparam int c_data_w = 32;
    localparam int c_reg_w  = 5;
    localparam int c_wb_w   = 2;
    localparam int c_m_w    = 3;
    localparam int c_cnt_w  = 16;

    localparam int c_wb_regwrite = 1;
    localparam int c_wb_memtoreg = 0;
    localparam int c_m_branch    = 2;
    localparam int c_m_memread   = 1;
    localparam int c_m_memwrite  = 0;

    localparam logic [c_cnt_w-1:0] c_cnt_max = '1;

    function automatic logic is_misaligned(input logic [1:0] byte_lsb);
        return |byte_lsb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
// ============================================================================
// Module : mem_wb_stage_if
// Brief  : EX/MEM inputs, branch feedback and write-back outputs of MEM/WB.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_wb_stage_if;
    import mem_wb_stage_pkg::*;

    logic [c_data_w-1:0] ALUout_in;
    logic                zero_in;
    logic [c_data_w-1:0] busB_in;
    logic [c_reg_w-1:0]  Rw_in;
    logic [c_wb_w-1:0]   WB_in;
    logic [c_m_w-1:0]    M_in;
    logic [c_data_w-1:0] ADDout_in;

    logic                PCSrc;
    logic [c_data_w-1:0] br_target;
    logic [c_reg_w-1:0]  Rw_wb;
    logic                RegWr;
    logic [c_data_w-1:0] busW;
    logic                mem_err;
    logic [c_cnt_w-1:0]  store_cnt;

    modport master (
        output ALUout_in, zero_in, busB_in, Rw_in, WB_in, M_in, ADDout_in,
        input  PCSrc, br_target, Rw_wb, RegWr, busW, mem_err, store_cnt
    );

    modport slave (
        input  ALUout_in, zero_in, busB_in, Rw_in, WB_in, M_in, ADDout_in,
        output PCSrc, br_target, Rw_wb, RegWr, busW, mem_err, store_cnt
    );

endinterface

`default_nettype wire

// File: rtl/mem_wb_stage_data_mem.sv
// ============================================================================
// Module : mem_wb_stage_data_mem
// Brief  : Word-addressed data memory, negedge write, combinational read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wb_stage_data_mem
    import mem_wb_stage_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                we,
    input  wire logic [ADDR_W-1:0]   idx,
    input  wire logic [c_data_w-1:0] wdata,
    output logic      [c_data_w-1:0] rdata
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [c_data_w-1:0] r_mem [c_depth];

    // Whole array clears asynchronously so a store in flight at reset is lost.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    assign rdata = r_mem[idx];

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module : mem_wb_stage
// Brief  : MEM stage with branch resolve, access checks and MEM/WB register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_wb_stage_if.slave bus
);

    logic                w_branch;
    logic                w_mem_read;
    logic                w_mem_write;
    logic                w_access;
    logic                w_misaligned;
    logic                w_conflict;
    logic                w_we;
    logic                w_cnt_sat;
    logic [ADDR_W-1:0]   w_idx;
    logic [c_data_w-1:0] w_rdata;
    logic [c_data_w-1:0] w_load_data;
    logic                w_unused_addr;

    logic [c_reg_w-1:0]  r_rw_wb;
    logic                r_regwr;
    logic                r_memtoreg_q;
    logic [c_data_w-1:0] r_alu_q;
    logic [c_data_w-1:0] r_mem_data_q;
    logic                r_mem_err;
    logic [c_cnt_w-1:0]  r_store_cnt;

    assign w_branch     = bus.M_in[c_m_branch];
    assign w_mem_read   = bus.M_in[c_m_memread];
    assign w_mem_write  = bus.M_in[c_m_memwrite];
    assign w_access     = w_mem_read | w_mem_write;
    assign w_misaligned = w_access & is_misaligned(bus.ALUout_in[1:0]);
    assign w_conflict   = w_mem_read & w_mem_write;
    assign w_we         = w_mem_write & ~w_misaligned;
    assign w_cnt_sat    = (r_store_cnt == c_cnt_max);

    // Address bits above the array span alias silently.
    assign w_idx         = bus.ALUout_in[ADDR_W+1:2];
    assign w_unused_addr = ^bus.ALUout_in[c_data_w-1:ADDR_W+2];

    // Read is pre-write, so a conflicting access returns the old word.
    assign w_load_data = w_misaligned ? '0 : w_rdata;

    mem_wb_stage_data_mem #(
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk   (clk),
        .reset (reset),
        .we    (w_we),
        .idx   (w_idx),
        .wdata (bus.busB_in),
        .rdata (w_rdata)
    );

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_rw_wb      <= '0;
            r_regwr      <= 1'b0;
            r_memtoreg_q <= 1'b0;
            r_alu_q      <= '0;
            r_mem_data_q <= '0;
            r_mem_err    <= 1'b0;
            r_store_cnt  <= '0;
        end else begin
            r_rw_wb      <= bus.Rw_in;
            r_regwr      <= bus.WB_in[c_wb_regwrite];
            r_memtoreg_q <= bus.WB_in[c_wb_memtoreg];
            r_alu_q      <= bus.ALUout_in;
            r_mem_data_q <= w_load_data;
            if (w_misaligned || w_conflict) begin
                r_mem_err <= 1'b1;
            end
            if (w_we && !w_cnt_sat) begin
                r_store_cnt <= r_store_cnt + 1'b1;
            end
        end
    end

    assign bus.PCSrc     = w_branch & bus.zero_in;
    assign bus.br_target = bus.ADDout_in;
    assign bus.Rw_wb     = r_rw_wb;
    assign bus.RegWr     = r_regwr;
    assign bus.busW      = r_memtoreg_q ? r_mem_data_q : r_alu_q;
    assign bus.mem_err   = r_mem_err;
    assign bus.store_cnt = r_store_cnt;

endmodule

`default_nettype wire
